br_update_collector: RTL and testbench
======================================

Name: br_update_collector

Overview:
- Sits between the integer execute pipes and the global-history-indexed branch predictor.
- Collects resolved-branch results from up to IN_WIDTH pipes per cycle and computes the new 2-bit saturating counter value for each result.
- Buffers those counter updates in an in-order FIFO and drains up to OUT_WIDTH writes per cycle into the predictor's counter table.
- Separately produces a registered global-history recovery event for the oldest mispredicted branch.

Parameters:
IN_WIDTH, 2, branch results accepted per cycle (lane 0 = oldest)
OUT_WIDTH, 2, counter writes issued per cycle
DEPTH, 8, update FIFO entries (power of two, >= IN_WIDTH)
HIST_WIDTH, 10, global history / counter index bits
CNT_WIDTH, 2, saturating counter bits; CNT_MAX = 2^CNT_WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  IN_WIDTH  lane i carries a resolved branch
in_history  in  IN_WIDTH*HIST_WIDTH  global history used at prediction (lane i at [i*HIST_WIDTH +: HIST_WIDTH])
in_prev_cnt  in  IN_WIDTH*CNT_WIDTH  counter value read at prediction
in_taken  in  IN_WIDTH  executed direction
in_mispred  in  IN_WIDTH  direction/target mispredicted
in_is_cond  in  IN_WIDTH  conditional branch
upd_stall  in  1  predictor cannot accept writes this cycle
upd_valid  out  OUT_WIDTH  write slot j valid (slot 0 = oldest)
upd_index  out  OUT_WIDTH*HIST_WIDTH  counter index for slot j
upd_cnt  out  OUT_WIDTH*CNT_WIDTH  new counter value for slot j
rec_valid  out  1  history recovery request
rec_history  out  HIST_WIDTH  corrected global history
count  out  $clog2(DEPTH)+1  FIFO occupancy
drop_count  out  8  saturating count of discarded updates

Behaviour:
- Reset: all outputs 0, FIFO empty, head/tail 0. Reset asserted mid-operation discards all queued entries and any pending recovery next edge.
- Counter arithmetic per valid lane:
  - taken: new = (prev == CNT_MAX) ? CNT_MAX : prev+1
  - not taken: new = (prev == 0) ? 0 : prev-1
  - All arithmetic in CNT_WIDTH bits; no wrap.
- Index = in_history unchanged.
- Push:
  - Valid lanes are compacted in lane order (older first) and written at the tail in one edge.
  - Each push writes {index, new cnt}.
  - Free = DEPTH - count after this cycle's pops.
  - If valid lanes exceed free space, the oldest `free` lanes are stored and the rest dropped; drop_count += number dropped, saturating at 255.
- Pop:
  - Outputs are driven combinationally from the FIFO head: upd_valid[j] = (count > j) && !upd_stall and !rst.
  - On each edge with !upd_stall, min(count, OUT_WIDTH) entries are removed.
  - Simultaneous push and pop in one edge is allowed; count_next = count - pops + pushes.
  - Pointers wrap modulo DEPTH.
- Latency: a result presented at edge N is visible on upd_* from cycle N+1 at the earliest.
- Full FIFO with upd_stall=0: pops happen first, so a full FIFO with two pops accepts two new lanes in the same edge.
- Recovery:
  - k = lowest lane with in_valid && in_mispred.
  - Next edge: rec_valid=1; rec_history = in_is_cond[k] ? ((in_history[k] << 1) | in_taken[k]) truncated to HIST_WIDTH : in_history[k].
  - rec_valid is high for exactly one cycle per mispredict event, unaffected by upd_stall or FIFO full.
  - Counter updates of lanes younger than k are still queued.
- State machine is not needed beyond FIFO pointers and the recovery register. Implementation is a register-array FIFO (no RAM macro).

Test Plan:
- Single taken branch: lane0 valid, history=0x155, prev=2, taken -> next cycle upd_valid=01, upd_index=0x155, upd_cnt=3; count returns to 0 the following edge.
- Saturation: prev=3 taken -> cnt 3; prev=0 not taken -> cnt 0; prev=1 not taken -> cnt 0.
- Ordering under stall: upd_stall=1 for 4 cycles, 2 results/cycle (histories 1..8) -> count=8; release stall -> upd_index pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles.
- Overflow: FIFO at 7 entries, stall held, two lanes valid -> lane0 stored, lane1 dropped, count=8, drop_count=1.
- Recovery: lane0 valid not mispred, lane1 mispred cond, history=0x3FF, taken=0 -> next cycle rec_valid=1 and rec_history=0x3FE for one cycle only; both counter updates queued. Repeat with in_is_cond=0 -> rec_history=0x3FF.
- Reset mid-operation: 5 entries queued plus pending mispredict, rst=1 for one edge -> count=0, upd_valid=0, rec_valid=0, drop_count=0.

Source files
------------

// File: rtl/br_update_collector.sv
// Collects resolved-branch results, computes saturating counter updates, queues them in an
// in-order register FIFO drained into the predictor table, and flags history recovery.
module br_update_collector #(
  parameter int unsigned IN_WIDTH   = 2,
  parameter int unsigned OUT_WIDTH  = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HIST_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WIDTH-1:0]              in_valid,
  input  logic [IN_WIDTH*HIST_WIDTH-1:0]   in_history,
  input  logic [IN_WIDTH*CNT_WIDTH-1:0]    in_prev_cnt,
  input  logic [IN_WIDTH-1:0]              in_taken,
  input  logic [IN_WIDTH-1:0]              in_mispred,
  input  logic [IN_WIDTH-1:0]              in_is_cond,
  input  logic                             upd_stall,
  output logic [OUT_WIDTH-1:0]             upd_valid,
  output logic [OUT_WIDTH*HIST_WIDTH-1:0]  upd_index,
  output logic [OUT_WIDTH*CNT_WIDTH-1:0]   upd_cnt,
  output logic                             rec_valid,
  output logic [HIST_WIDTH-1:0]            rec_history,
  output logic [$clog2(DEPTH):0]           count,
  output logic [7:0]                       drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [HIST_WIDTH-1:0] fifoIndex [DEPTH];
  logic [CNT_WIDTH-1:0]  fifoCnt   [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  logic [CNT_WIDTH-1:0]  laneCnt   [IN_WIDTH];
  logic [OCC_W-1:0]      lanePos   [IN_WIDTH];
  logic [IN_WIDTH-1:0]   laneStore;
  logic [OCC_W-1:0]      popNum;
  logic [OCC_W-1:0]      freeSlots;
  logic [OCC_W-1:0]      validCount;
  logic [OCC_W-1:0]      pushNum;
  logic [OCC_W-1:0]      dropNum;
  logic [8:0]            dropSum;
  logic [7:0]            dropNext;
  logic                  recHit;
  logic [HIST_WIDTH-1:0] recHist;

  // Saturating counter step per lane
  always_comb begin
    logic [CNT_WIDTH-1:0] prev;
    prev = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      prev = in_prev_cnt[i*CNT_WIDTH +: CNT_WIDTH];
      if (in_taken[i]) begin
        laneCnt[i] = (prev == CNT_MAX) ? CNT_MAX : prev + CNT_WIDTH'(1);
      end else begin
        laneCnt[i] = (prev == '0) ? '0 : prev - CNT_WIDTH'(1);
      end
    end
  end

  // Pops are resolved first so a full FIFO that drains can refill in the same edge
  always_comb begin
    popNum     = upd_stall ? '0 : ((count < OCC_W'(OUT_WIDTH)) ? count : OCC_W'(OUT_WIDTH));
    freeSlots  = OCC_W'(DEPTH) - (count - popNum);
    validCount = '0;
    laneStore  = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      lanePos[i]   = validCount;
      laneStore[i] = in_valid[i] && (validCount < freeSlots);
      if (in_valid[i]) begin
        validCount = validCount + OCC_W'(1);
      end
    end
    pushNum  = (validCount < freeSlots) ? validCount : freeSlots;
    dropNum  = validCount - pushNum;
    dropSum  = {1'b0, drop_count} + 9'(dropNum);
    dropNext = dropSum[8] ? 8'hFF : dropSum[7:0];
  end

  // Oldest mispredicted lane wins the recovery slot
  always_comb begin
    logic [HIST_WIDTH-1:0] hist;
    hist    = '0;
    recHit  = 1'b0;
    recHist = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (!recHit && in_valid[i] && in_mispred[i]) begin
        recHit  = 1'b1;
        hist    = in_history[i*HIST_WIDTH +: HIST_WIDTH];
        recHist = in_is_cond[i] ? {hist[HIST_WIDTH-2:0], in_taken[i]} : hist;
      end
    end
  end

  always_comb begin
    upd_valid = '0;
    upd_index = '0;
    upd_cnt   = '0;
    for (int unsigned j = 0; j < OUT_WIDTH; j++) begin
      if (!rst && !upd_stall && (count > OCC_W'(j))) begin
        upd_valid[j]                         = 1'b1;
        upd_index[j*HIST_WIDTH +: HIST_WIDTH] = fifoIndex[head + PTR_W'(j)];
        upd_cnt[j*CNT_WIDTH +: CNT_WIDTH]     = fifoCnt[head + PTR_W'(j)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      drop_count  <= '0;
      rec_valid   <= 1'b0;
      rec_history <= '0;
    end else begin
      head       <= head + PTR_W'(popNum);
      tail       <= tail + PTR_W'(pushNum);
      count      <= count - popNum + pushNum;
      drop_count <= dropNext;
      rec_valid  <= recHit;
      if (recHit) begin
        rec_history <= recHist;
      end
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
        if (laneStore[i]) begin
          fifoIndex[tail + PTR_W'(lanePos[i])] <= in_history[i*HIST_WIDTH +: HIST_WIDTH];
          fifoCnt[tail + PTR_W'(lanePos[i])]   <= laneCnt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_br_update_collector.sv
// Directed self-checking bench for br_update_collector with hand-computed expectations.
module tb_br_update_collector;

  localparam int unsigned IW = 2;
  localparam int unsigned OW = 2;
  localparam int unsigned HW = 10;
  localparam int unsigned CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [IW-1:0]  in_valid;
  logic [IW*HW-1:0] in_history;
  logic [IW*CW-1:0] in_prev_cnt;
  logic [IW-1:0]  in_taken;
  logic [IW-1:0]  in_mispred;
  logic [IW-1:0]  in_is_cond;
  logic           upd_stall;
  logic [OW-1:0]  upd_valid;
  logic [OW*HW-1:0] upd_index;
  logic [OW*CW-1:0] upd_cnt;
  logic           rec_valid;
  logic [HW-1:0]  rec_history;
  logic [3:0]     count;
  logic [7:0]     drop_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  br_update_collector #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(8), .HIST_WIDTH(HW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_history(in_history), .in_prev_cnt(in_prev_cnt),
    .in_taken(in_taken), .in_mispred(in_mispred), .in_is_cond(in_is_cond),
    .upd_stall(upd_stall),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_cnt(upd_cnt),
    .rec_valid(rec_valid), .rec_history(rec_history),
    .count(count), .drop_count(drop_count)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idxPair(input logic [HW-1:0] slot0, input logic [HW-1:0] slot1);
    return (32'(slot1) << HW) | 32'(slot0);
  endfunction

  task automatic clearIn();
    in_valid = '0; in_history = '0; in_prev_cnt = '0;
    in_taken = '0; in_mispred = '0; in_is_cond = '0;
  endtask

  task automatic setLane(input int lane, input logic [HW-1:0] hist, input logic [CW-1:0] prev,
                         input logic taken, input logic mis, input logic cond);
    in_valid[lane]             = 1'b1;
    in_history[lane*HW +: HW]  = hist;
    in_prev_cnt[lane*CW +: CW] = prev;
    in_taken[lane]             = taken;
    in_mispred[lane]           = mis;
    in_is_cond[lane]           = cond;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clearIn();
  endtask

  initial begin
    rst = 1'b1;
    upd_stall = 1'b0;
    clearIn();
    tick();
    tick();
    checkEq("rst_count", 32'(count), 32'd0);
    checkEq("rst_upd_valid", 32'(upd_valid), 32'd0);
    checkEq("rst_upd_index", 32'(upd_index), 32'd0);
    checkEq("rst_rec_valid", 32'(rec_valid), 32'd0);
    checkEq("rst_rec_history", 32'(rec_history), 32'd0);
    checkEq("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;

    // single taken branch
    setLane(0, 10'h155, 2'd2, 1'b1, 1'b0, 1'b1);
    checkEq("single_pre_valid", 32'(upd_valid), 32'd0);
    tick();
    checkEq("single_valid", 32'(upd_valid), 32'b01);
    checkEq("single_index", 32'(upd_index), 32'h155);
    checkEq("single_cnt", 32'(upd_cnt), 32'd3);
    checkEq("single_count", 32'(count), 32'd1);
    tick();
    checkEq("single_drained", 32'(count), 32'd0);
    checkEq("single_idle_valid", 32'(upd_valid), 32'd0);

    // saturation at both ends, plus simultaneous pop and push
    setLane(0, 10'd1, 2'd3, 1'b1, 1'b0, 1'b1);
    setLane(1, 10'd2, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkEq("sat_valid", 32'(upd_valid), 32'b11);
    checkEq("sat_index", 32'(upd_index), idxPair(10'd1, 10'd2));
    checkEq("sat_cnt_hi_lo", 32'(upd_cnt), 32'b0011);
    setLane(0, 10'd3, 2'd1, 1'b0, 1'b0, 1'b1);
    setLane(1, 10'd4, 2'd2, 1'b0, 1'b0, 1'b1);
    tick();
    checkEq("sat_pp_count", 32'(count), 32'd2);
    checkEq("sat_pp_index", 32'(upd_index), idxPair(10'd3, 10'd4));
    checkEq("sat_pp_cnt", 32'(upd_cnt), 32'b0100);
    tick();
    checkEq("sat_drained", 32'(count), 32'd0);

    // ordering under stall
    upd_stall = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      setLane(0, 10'(2*c-1), 2'd1, 1'b1, 1'b0, 1'b1);
      setLane(1, 10'(2*c), 2'd1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    checkEq("ord_count_full", 32'(count), 32'd8);
    checkEq("ord_stalled_valid", 32'(upd_valid), 32'd0);
    upd_stall = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      checkEq("ord_valid", 32'(upd_valid), 32'b11);
      checkEq("ord_index", 32'(upd_index), idxPair(10'(2*p+1), 10'(2*p+2)));
      checkEq("ord_cnt", 32'(upd_cnt), 32'b1010);
      tick();
    end
    checkEq("ord_drained", 32'(count), 32'd0);

    // overflow and full-FIFO refill
    upd_stall = 1'b1;
    setLane(0, 10'h10, 2'd0, 1'b1, 1'b0, 1'b1); setLane(1, 10'h11, 2'd0, 1'b1, 1'b0, 1'b1); tick();
    setLane(0, 10'h12, 2'd0, 1'b1, 1'b0, 1'b1); setLane(1, 10'h13, 2'd0, 1'b1, 1'b0, 1'b1); tick();
    setLane(0, 10'h14, 2'd0, 1'b1, 1'b0, 1'b1); setLane(1, 10'h15, 2'd0, 1'b1, 1'b0, 1'b1); tick();
    setLane(0, 10'h16, 2'd0, 1'b1, 1'b0, 1'b1); tick();
    checkEq("ovf_count7", 32'(count), 32'd7);
    setLane(0, 10'h17, 2'd0, 1'b1, 1'b0, 1'b1); setLane(1, 10'h18, 2'd0, 1'b1, 1'b0, 1'b1); tick();
    checkEq("ovf_count8", 32'(count), 32'd8);
    checkEq("ovf_drop1", 32'(drop_count), 32'd1);
    setLane(0, 10'h19, 2'd0, 1'b1, 1'b0, 1'b1); setLane(1, 10'h1A, 2'd0, 1'b1, 1'b0, 1'b1); tick();
    checkEq("ovf_drop3", 32'(drop_count), 32'd3);
    upd_stall = 1'b0;
    setLane(0, 10'h20, 2'd0, 1'b1, 1'b0, 1'b1); setLane(1, 10'h21, 2'd0, 1'b1, 1'b0, 1'b1);
    #1;
    checkEq("full_head_index", 32'(upd_index), idxPair(10'h10, 10'h11));
    tick();
    checkEq("full_refill_count", 32'(count), 32'd8);
    checkEq("full_refill_drop", 32'(drop_count), 32'd3);
    checkEq("full_next_index", 32'(upd_index), idxPair(10'h12, 10'h13));
    tick(); tick();
    checkEq("ovf_kept_tail", 32'(upd_index), idxPair(10'h16, 10'h17));
    tick();
    checkEq("full_refill_data", 32'(upd_index), idxPair(10'h20, 10'h21));
    checkEq("full_refill_cnt", 32'(upd_cnt), 32'b0101);
    tick();
    checkEq("ovf_drained", 32'(count), 32'd0);

    // recovery, conditional
    setLane(0, 10'h001, 2'd1, 1'b1, 1'b0, 1'b1);
    setLane(1, 10'h3FF, 2'd2, 1'b0, 1'b1, 1'b1);
    tick();
    checkEq("rec_cond_valid", 32'(rec_valid), 32'd1);
    checkEq("rec_cond_hist", 32'(rec_history), 32'h3FE);
    checkEq("rec_both_queued", 32'(count), 32'd2);
    checkEq("rec_upd_index", 32'(upd_index), idxPair(10'h001, 10'h3FF));
    checkEq("rec_upd_cnt", 32'(upd_cnt), 32'b0110);
    tick();
    checkEq("rec_one_cycle", 32'(rec_valid), 32'd0);
    // recovery, unconditional
    setLane(0, 10'h001, 2'd1, 1'b1, 1'b0, 1'b1);
    setLane(1, 10'h3FF, 2'd2, 1'b0, 1'b1, 1'b0);
    tick();
    checkEq("rec_ucond_valid", 32'(rec_valid), 32'd1);
    checkEq("rec_ucond_hist", 32'(rec_history), 32'h3FF);
    tick();
    checkEq("rec_ucond_one_cycle", 32'(rec_valid), 32'd0);
    // oldest lane wins, shift truncates
    setLane(0, 10'h200, 2'd1, 1'b1, 1'b1, 1'b1);
    setLane(1, 10'h0AA, 2'd1, 1'b1, 1'b1, 1'b1);
    tick();
    checkEq("rec_oldest_hist", 32'(rec_history), 32'h001);
    tick();

    // reset mid-operation
    upd_stall = 1'b1;
    setLane(0, 10'd1, 2'd1, 1'b1, 1'b0, 1'b1); setLane(1, 10'd2, 2'd1, 1'b1, 1'b0, 1'b1); tick();
    setLane(0, 10'd3, 2'd1, 1'b1, 1'b0, 1'b1); setLane(1, 10'd4, 2'd1, 1'b1, 1'b0, 1'b1); tick();
    setLane(0, 10'd5, 2'd1, 1'b1, 1'b0, 1'b1); tick();
    checkEq("mid_count5", 32'(count), 32'd5);
    rst = 1'b1;
    setLane(0, 10'h123, 2'd1, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    upd_stall = 1'b0;
    #1;
    checkEq("mid_rst_count", 32'(count), 32'd0);
    checkEq("mid_rst_valid", 32'(upd_valid), 32'd0);
    checkEq("mid_rst_rec", 32'(rec_valid), 32'd0);
    checkEq("mid_rst_drop", 32'(drop_count), 32'd0);
    tick();
    checkEq("mid_post_count", 32'(count), 32'd0);
    checkEq("mid_post_rec", 32'(rec_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
